// File: rtl/bcd_add_align_if.sv
// bcd_add_align_if: operand/result bundle between the BCD adder front end and its pre-alignment stage.
interface bcd_add_align_if #(parameter int N = 33, parameter int EW = 12);
  logic ce, valid_i, op_i, sa_i, sb_i;
  logic [EW-1:0] ea_i, eb_i;
  logic [8*N-1:0] ma_i, mb_i;
  logic valid_o, ci_o, sub_o, sign_o, sticky_o, eq_o, inv_o;
  logic [8*N-1:0] a_o, b_o;
  logic [EW-1:0] exp_o;
  modport master (
    output ce, valid_i, op_i, sa_i, sb_i, ea_i, eb_i, ma_i, mb_i,
    input valid_o, a_o, b_o, ci_o, sub_o, sign_o, exp_o, sticky_o, eq_o, inv_o
  );
  modport slave (
    input ce, valid_i, op_i, sa_i, sb_i, ea_i, eb_i, ma_i, mb_i,
    output valid_o, a_o, b_o, ci_o, sub_o, sign_o, exp_o, sticky_o, eq_o, inv_o
  );
endinterface

// File: rtl/bcd_add_align.sv
// bcd_add_align: 3-stage swap / align / nines-complement front end for the decimal adder.
module bcd_add_align #(parameter int N = 33, parameter int EW = 12) (
  input logic clk,
  input logic rst,
  bcd_add_align_if.slave bus
);
  localparam int W = 8*N;
  localparam int SW = $clog2(2*N+1);
  logic v1_q, eff1_q, inv1_q, swap1_q, eq1_q, sign1_q;
  logic [EW-1:0] exp1_q;
  logic [EW:0] d1_q;
  logic [W-1:0] ma1_q, mb1_q;
  logic v2_q, st2_q, eff2_q, inv2_q, eq2_q, sign2_q;
  logic [EW-1:0] exp2_q;
  logic [W-1:0] a2_q, b2_q;
  logic v3_q, st3_q, eff3_q, inv3_q, eq3_q, sign3_q;
  logic [EW-1:0] exp3_q;
  logic [W-1:0] a3_q, b3_q;
  logic inv_d, eff_d, swap_d, eq_d, sign_d, st_d;
  logic [EW:0] ad;
  logic [SW-1:0] sh;
  logic [W-1:0] bs, b2_d, b3_d;
  always_comb begin
    inv_d = 1'b0;
    for (int i = 0; i < 2*N; i++)
      inv_d = inv_d | (bus.ma_i[4*i+:4] > 4'd9) | (bus.mb_i[4*i+:4] > 4'd9);
    eff_d = bus.sa_i ^ bus.sb_i ^ bus.op_i;
    swap_d = (bus.eb_i > bus.ea_i) || (bus.eb_i == bus.ea_i && bus.mb_i > bus.ma_i);
    eq_d = (bus.ea_i == bus.eb_i) && (bus.ma_i == bus.mb_i);
    // Exact cancellation is forced to +0 regardless of operand signs.
    sign_d = (eq_d && eff_d) ? 1'b0 : swap_d ? bus.sb_i ^ bus.op_i : bus.sa_i;
  end
  always_comb begin
    ad = d1_q[EW] ? -d1_q : d1_q;
    sh = (ad > (EW+1)'(2*N)) ? SW'(2*N) : SW'(ad);
    bs = swap1_q ? ma1_q : mb1_q;
    b2_d = bs >> {sh, 2'b00};
    st_d = |(bs & ~({W{1'b1}} << {sh, 2'b00}));
  end
  always_comb begin
    b3_d = b2_q;
    for (int i = 0; i < 2*N; i++)
      b3_d[4*i+:4] = eff2_q ? 4'd9 - b2_q[4*i+:4] : b2_q[4*i+:4];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {v1_q, eff1_q, inv1_q, swap1_q, eq1_q, sign1_q, exp1_q, d1_q, ma1_q, mb1_q} <= '0;
      {v2_q, st2_q, eff2_q, inv2_q, eq2_q, sign2_q, exp2_q, a2_q, b2_q} <= '0;
      {v3_q, st3_q, eff3_q, inv3_q, eq3_q, sign3_q, exp3_q, a3_q, b3_q} <= '0;
    end else if (bus.ce) begin
      v1_q <= bus.valid_i;
      eff1_q <= eff_d;
      inv1_q <= inv_d;
      swap1_q <= swap_d;
      eq1_q <= eq_d;
      sign1_q <= sign_d;
      exp1_q <= swap_d ? bus.eb_i : bus.ea_i;
      d1_q <= {1'b0, bus.ea_i} - {1'b0, bus.eb_i};
      ma1_q <= bus.ma_i;
      mb1_q <= bus.mb_i;
      v2_q <= v1_q;
      st2_q <= st_d;
      eff2_q <= eff1_q;
      inv2_q <= inv1_q;
      eq2_q <= eq1_q;
      sign2_q <= sign1_q;
      exp2_q <= exp1_q;
      a2_q <= swap1_q ? mb1_q : ma1_q;
      b2_q <= b2_d;
      v3_q <= v2_q;
      st3_q <= st2_q;
      eff3_q <= eff2_q;
      inv3_q <= inv2_q;
      eq3_q <= eq2_q;
      sign3_q <= sign2_q;
      exp3_q <= exp2_q;
      a3_q <= a2_q;
      b3_q <= b3_d;
    end
  assign bus.valid_o = v3_q;
  assign bus.a_o = a3_q;
  assign bus.b_o = b3_q;
  assign bus.ci_o = eff3_q;
  assign bus.sub_o = eff3_q;
  assign bus.sign_o = sign3_q;
  assign bus.exp_o = exp3_q;
  assign bus.sticky_o = st3_q;
  assign bus.eq_o = eq3_q;
  assign bus.inv_o = inv3_q;
endmodule

// File: tb/tb_bcd_add_align.sv
// tb_bcd_add_align: scoreboard bench with a decimal-arithmetic reference model, N=2 (4 digits), EW=12.
module tb_bcd_add_align;
  typedef struct packed {
    logic [15:0] a, b;
    logic ci, sub, sign;
    logic [11:0] ex;
    logic sticky, eq, inv;
  } res_t;
  logic clk = 0, rst = 1;
  int checks = 0, errors = 0;
  res_t q[$];
  logic [49:0] got, snap;
  bcd_add_align_if #(.N(2), .EW(12)) bus ();
  bcd_add_align #(.N(2), .EW(12)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign got = {bus.a_o, bus.b_o, bus.ci_o, bus.sub_o, bus.sign_o, bus.exp_o, bus.sticky_o, bus.eq_o, bus.inv_o};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] m);
    int v = 0;
    for (int i = 3; i >= 0; i--) v = v * 10 + int'(m[4*i+:4]);
    return v;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] m;
    for (int i = 0; i < 4; i++) begin
      m[4*i+:4] = 4'(v % 10);
      v = v / 10;
    end
    return m;
  endfunction

  function automatic res_t model(input logic o, sa, sb, input logic [11:0] ea, eb, input logic [15:0] ma, mb);
    res_t r;
    logic sw, eff;
    int sh, bv, p;
    eff = sa ^ sb ^ o;
    sw = (eb > ea) || (eb == ea && mb > ma);
    sh = (ea > eb) ? int'(ea) - int'(eb) : int'(eb) - int'(ea);
    if (sh > 4) sh = 4;
    bv = bcd2int(sw ? ma : mb);
    p = 10 ** sh;
    r.sticky = (bv % p) != 0;
    bv = bv / p;
    if (eff) bv = 9999 - bv;
    r.a = sw ? mb : ma;
    r.b = int2bcd(bv);
    r.ci = eff;
    r.sub = eff;
    r.eq = (ea == eb) && (ma == mb);
    r.sign = (r.eq && eff) ? 1'b0 : sw ? sb ^ o : sa;
    r.ex = sw ? eb : ea;
    r.inv = 1'b0;
    for (int i = 0; i < 4; i++) r.inv = r.inv | (ma[4*i+:4] > 4'd9) | (mb[4*i+:4] > 4'd9);
    return r;
  endfunction

  task automatic drive(input logic v, c, o, sa, sb, input logic [11:0] ea, eb, input logic [15:0] ma, mb);
    @(negedge clk);
    bus.valid_i = v; bus.ce = c; bus.op_i = o; bus.sa_i = sa; bus.sb_i = sb;
    bus.ea_i = ea; bus.eb_i = eb; bus.ma_i = ma; bus.mb_i = mb;
    if (v && c) q.push_back(model(o, sa, sb, ea, eb, ma, mb));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [15:0] rbcd();
    logic [15:0] m;
    for (int i = 0; i < 4; i++) m[4*i+:4] = 4'($urandom_range(0, 9));
    return m;
  endfunction

  initial begin : monitor
    logic ce_s, rst_s;
    res_t e;
    forever begin
      @(posedge clk);
      ce_s = bus.ce;
      rst_s = rst;
      #1;
      if (!rst_s && !rst && ce_s && bus.valid_o) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid_o: got valid_o=1 with outputs %h, expected no output", got);
        end else begin
          e = q.pop_front();
          chk("result", 64'(got), 64'(e));
        end
      end
    end
  end

  initial begin : stim
    logic [11:0] ea, eb;
    logic [15:0] ma;
    int t;
    bus.ce = 1; bus.valid_i = 0; bus.op_i = 0; bus.sa_i = 0; bus.sb_i = 0;
    bus.ea_i = 0; bus.eb_i = 0; bus.ma_i = 0; bus.mb_i = 0;
    #1;
    chk("reset_outputs", 64'(got), 64'd0);
    chk("reset_valid", 64'(bus.valid_o), 64'd0);
    idle(2);
    rst = 0;
    idle(2);
    drive(1, 1, 0, 0, 0, 100, 100, 16'h1234, 16'h0567);
    drive(1, 1, 0, 0, 0, 98, 100, 16'h0012, 16'h5000);
    drive(1, 1, 0, 0, 0, 99, 100, 16'h0012, 16'h5000);
    drive(1, 1, 1, 0, 0, 200, 200, 16'h5000, 16'h1234);
    drive(1, 1, 1, 0, 0, 200, 200, 16'h1234, 16'h5000);
    drive(1, 1, 0, 0, 1, 300, 300, 16'h4321, 16'h4321);
    drive(1, 1, 0, 0, 0, 0, 4095, 16'h0789, 16'h1000);
    drive(1, 1, 0, 0, 0, 0, 4095, 16'h0000, 16'h1000);
    drive(1, 1, 1, 1, 0, 4095, 0, 16'h0001, 16'h9999);
    drive(1, 1, 0, 0, 0, 50, 50, 16'h12A4, 16'h0000);
    idle(4);
    for (int i = 0; i < 5; i++) drive(1, 1, 1'($urandom), 1'($urandom), 1'($urandom), 12'(500 + i), 12'(502 - i), rbcd(), rbcd());
    drive(1, 0, 0, 0, 0, 7, 7, 16'h1111, 16'h2222);
    snap = got;
    chk("stall_valid", 64'(bus.valid_o), 64'd1);
    drive(1, 0, 0, 0, 0, 7, 7, 16'h3333, 16'h4444);
    drive(1, 1, 0, 1, 1, 321, 320, 16'h9876, 16'h0505);
    chk("stall_hold", 64'(got), 64'(snap));
    idle(5);
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, 0, 12'(10 + i), 10, rbcd(), rbcd());
    @(negedge clk);
    rst = 1;
    #1;
    chk("midreset_outputs", 64'(got), 64'd0);
    chk("midreset_valid", 64'(bus.valid_o), 64'd0);
    q.delete();
    idle(2);
    rst = 0;
    idle(6);
    chk("no_stale_valid", 64'(bus.valid_o), 64'd0);
    for (int i = 0; i < 300; i++) begin
      ea = 12'($urandom_range(0, 4095));
      t = int'(ea) + $urandom_range(0, 12) - 6;
      if ($urandom_range(0, 9) == 0) t = $urandom_range(0, 4095);
      eb = 12'(t < 0 ? 0 : t > 4095 ? 4095 : t);
      ma = rbcd();
      drive(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 4) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
            ea, eb, ma, $urandom_range(0, 5) == 0 ? ma : rbcd());
    end
    for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
    chk("drain_empty", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_add_align.md
# bcd_add_align

Pre-alignment stage for the decimal floating-point adder. It takes two packed-BCD operands, each with a sign, a biased exponent and a significand of 2N digits, and swaps them so the larger magnitude is on the A side. It then shifts the smaller significand right by the exponent difference and converts an effective subtraction into ten's-complement form. The outputs `a_o`, `b_o` and `ci_o` drive the BCD carry-save adder directly, and the fixed 3-cycle latency keeps the adder's input timing predictable.

## Interface
- `N`, default 33: significand width in bytes; each byte holds two BCD digits, giving 2N digits.
- `EW`, default 12: biased exponent width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ce` in 1: clock enable; when low, every pipeline register holds its value.
- `valid_i` in 1: input operands are valid this cycle.
- `op_i` in 1: 0 = add, 1 = subtract (A − B).
- `sa_i`, `sb_i` in 1: operand signs.
- `ea_i`, `eb_i` in EW: biased exponents.
- `ma_i`, `mb_i` in N*8: packed-BCD significands, most significant digit in the top nibble.
- `valid_o` out 1: outputs valid.
- `a_o` out N*8: larger-magnitude significand.
- `b_o` out N*8: aligned smaller significand, nines-complemented when `sub_o` = 1.
- `ci_o` out 1: adder carry-in; equals `sub_o`.
- `sub_o` out 1: effective subtraction.
- `sign_o` out 1: tentative result sign.
- `exp_o` out EW: result exponent, which is the larger exponent.
- `sticky_o` out 1: OR of all nonzero digits shifted out of B.
- `eq_o` out 1: the two magnitudes are exactly equal.
- `inv_o` out 1: some input digit is greater than 9.

## Operation
- **Stage 1 (S1, registered)**
  - Capture the inputs.
  - Compute `d = ea_i − eb_i` as EW+1 bits, signed.
  - Compute `eff = sa_i ^ sb_i ^ op_i`.
  - Compute `inv` = OR over all digits of (digit > 9).
  - Set `swap` when `eb > ea`, or when `eb == ea` and `mb > ma`. Packed BCD compares correctly as an unsigned binary number.
  - Set `eq = (ea == eb) && (ma == mb)`.
- **Stage 2 (S2, registered)**
  - The larger operand goes to A and the smaller to B.
  - `sh = |d|`, saturated at 2N.
  - B is shifted right by `sh` digits, 4 bits per digit, with zero fill.
  - `sticky` = OR of the shifted-out bits. When `sh` = 2N, B becomes 0 and `sticky` = (B ≠ 0).
- **Stage 3 (S3, registered)**
  - If `eff` = 1, each digit of B is replaced by 9 − digit, and `ci_o` = 1.
  - `sign_o`:
    - if `eq` and `eff`: 0 (exact cancellation gives +0);
    - else if `swap`: `sb ^ op`;
    - else: `sa`.
  - `exp_o` = max(ea, eb).
- **Scope of this stage**
  - The sticky digit is not folded into the complement; rounding downstream applies the correction.
  - `inv_o` is a flag only. Data passes through unchanged.
- **Pipeline**
  - `valid` travels with the data.
  - All stages advance only when `ce` = 1.
  - There is no backpressure beyond `ce`, and a new operand pair is accepted every enabled cycle.

## Timing
- **Latency:** 3 enabled clocks from `valid_i` to `valid_o`. Throughput is 1 per enabled clock.
- **Reset:** all pipeline registers and all outputs are 0 on reset, including `valid_o`, `a_o`, `b_o`, `ci_o`, `sub_o`, `sign_o`, `exp_o`, `sticky_o`, `eq_o` and `inv_o`.
  - Reset asserted mid-operation discards every in-flight operand. `valid_o` is low until 3 enabled clocks after the first new `valid_i` following reset release.
- **`ce` low:** outputs hold, including `valid_o`. Stages do not collapse bubbles.
- **Don't-care data:** when `valid_i` = 0, data registers may load don't-care values, but `valid` must be 0 in that stage.
- **Exponent difference at its extremes:** a difference of ±(2^EW − 1) saturates the shift to 2N without wrap-around.
- **Downstream:** the adder adds 3 further clocks, so end-to-end add latency is 6 enabled clocks.

## Test plan
- **Equal exponents, add:** N=2, `ma`=1234, `mb`=0567, `ea`=`eb`=100, `op`=0, signs + → `a_o`=1234, `b_o`=0567, `ci_o`=0, `sign_o`=0, `exp_o`=100, `sticky_o`=0.
- **Swap and shift:** `ma`=0012, `ea`=98; `mb`=5000, `eb`=100 → `a_o`=5000, `b_o`=0000, `sticky_o`=1, `exp_o`=100. Repeat with `ea`=99 → `b_o`=0001, `sticky_o`=1.
- **Effective subtract:** `ma`=5000, `mb`=1234, `op`=1, equal exponents → `b_o`=8765, `ci_o`=1, `sub_o`=1, `sign_o`=0. Repeat with operands swapped → `a_o`=5000, `sign_o`=1.
- **Exact cancellation:** `ma`=`mb`=4321, equal exponents, `sa`=0, `sb`=1, `op`=0 → `eq_o`=1, `sub_o`=1, `sign_o`=0.
- **Pipeline, `ce` and reset:** three back-to-back `valid_i` pulses with `ce` dropped for 2 cycles in the middle → outputs appear in order and hold during the stall. Assert `rst` mid-stream → all outputs 0 immediately, and no stale `valid_o` appears after release.
- **Saturation and invalid digits:** `ea`=0, `eb`=4095 (EW=12) → shift saturates, `b_o`=0, `sticky_o` = (`ma` ≠ 0). `ma`=0x12A4 → `inv_o`=1.
